bp_fe_fetch_replay_queue: RTL and testbench

BP_FE_FETCH_REPLAY_QUEUE -- requirements
Module: bp_fe_fetch_replay_queue

---
 rtl/bp_fe_fetch_replay_queue.sv | 94 +++++++++
 tb/tb_bp_fe_fetch_replay_queue.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/bp_fe_fetch_replay_queue.sv
// Fetch replay queue: FIFO with a speculative read pointer that can be rolled back
// to the commit pointer, so consumed-but-uncommitted entries can be replayed.
module bp_fe_fetch_replay_queue #(
  parameter int unsigned els_p   = 8,
  parameter int unsigned width_p = 64
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       clr_v_i,
  input  logic                       v_i,
  input  logic [width_p-1:0]         data_i,
  output logic                       ready_and_o,
  output logic                       v_o,
  output logic [width_p-1:0]         data_o,
  input  logic                       yumi_i,
  input  logic                       commit_v_i,
  input  logic                       roll_v_i,
  output logic                       empty_o,
  output logic [$clog2(els_p+1)-1:0] count_o
);

  localparam int unsigned idx_width_lp = $clog2(els_p);
  localparam int unsigned ptr_width_lp = idx_width_lp + 1;
  localparam int unsigned cnt_width_lp = $clog2(els_p + 1);

  typedef logic [ptr_width_lp-1:0] ptr_t;
  localparam ptr_t ptr_one = ptr_t'(1);

  ptr_t wptr_q, wptr_d;
  ptr_t rptr_q, rptr_d;
  ptr_t cptr_q, cptr_d;
  ptr_t used;

  logic [width_p-1:0] mem_q [els_p];

  logic full;
  logic enq;

  // Full when the index bits match but the wrap bits differ.
  assign full = (wptr_q[idx_width_lp-1:0] == cptr_q[idx_width_lp-1:0])
             && (wptr_q[idx_width_lp] != cptr_q[idx_width_lp]);

  assign ready_and_o = ~full;
  assign enq         = v_i & ready_and_o;
  assign v_o         = (rptr_q != wptr_q);
  assign data_o      = mem_q[rptr_q[idx_width_lp-1:0]];
  assign empty_o     = (wptr_q == cptr_q);
  assign used        = wptr_q - cptr_q;
  assign count_o     = cnt_width_lp'(used);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cptr_d = cptr_q;
    if (clr_v_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cptr_d = '0;
    end else begin
      if (enq)        wptr_d = wptr_q + ptr_one;
      if (commit_v_i) cptr_d = cptr_q + ptr_one;
      // Roll rewinds to the post-commit pointer and overrides any yumi.
      if (roll_v_i)    rptr_d = cptr_d;
      else if (yumi_i) rptr_d = rptr_q + ptr_one;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cptr_q <= cptr_d;
    end
  end

  // Payload storage is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (enq && !clr_v_i) begin
      mem_q[wptr_q[idx_width_lp-1:0]] <= data_i;
    end
  end

  always @(posedge clk_i) begin
    if (!reset_i && !clr_v_i) begin
      assert (!(commit_v_i && (cptr_q == rptr_q)));
      assert (!(yumi_i && !v_o));
    end
  end

endmodule

// File: tb/tb_bp_fe_fetch_replay_queue.sv
// Randomized bench for the fetch replay queue, checked against a queue-based model
// holding all live entries plus a count of consumed-but-uncommitted ones.
module tb_bp_fe_fetch_replay_queue;

  localparam int unsigned Els = 4;
  localparam int unsigned W   = 8;

  logic         clk = 1'b0;
  logic         reset_i;
  logic         clr_v_i, v_i, yumi_i, commit_v_i, roll_v_i;
  logic [W-1:0] data_i, data_o;
  logic         ready_and_o, v_o, empty_o;
  logic [2:0]   count_o;

  int n_checks = 0;
  int n_fail   = 0;

  byte unsigned mq[$];
  int           consumed = 0;

  always #5 clk = ~clk;

  bp_fe_fetch_replay_queue #(.els_p(Els), .width_p(W)) dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .clr_v_i    (clr_v_i),
    .v_i        (v_i),
    .data_i     (data_i),
    .ready_and_o(ready_and_o),
    .v_o        (v_o),
    .data_o     (data_o),
    .yumi_i     (yumi_i),
    .commit_v_i (commit_v_i),
    .roll_v_i   (roll_v_i),
    .empty_o    (empty_o),
    .count_o    (count_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_state(input string tag);
    int sz;
    sz = mq.size();
    check({tag, ".count"}, 32'(count_o), 32'(sz));
    check({tag, ".ready"}, 32'(ready_and_o), 32'(sz < int'(Els)));
    check({tag, ".v_o"}, 32'(v_o), 32'(consumed < sz));
    check({tag, ".empty"}, 32'(empty_o), 32'(sz == 0));
    if (consumed < sz) check({tag, ".data"}, 32'(data_o), 32'(mq[consumed]));
  endtask

  task automatic idle_inputs();
    v_i = 1'b0; data_i = '0; yumi_i = 1'b0; commit_v_i = 1'b0; roll_v_i = 1'b0; clr_v_i = 1'b0;
  endtask

  // One clock cycle of stimulus, model update and full state check.
  task automatic step(input string tag, input logic v, input logic [W-1:0] d, input logic y,
                      input logic c, input logic r, input logic cl);
    logic enq;
    v_i = v; data_i = d; yumi_i = y; commit_v_i = c; roll_v_i = r; clr_v_i = cl;
    enq = v && (mq.size() < int'(Els));
    @(posedge clk);
    #1;
    if (cl) begin
      mq.delete();
      consumed = 0;
    end else begin
      if (c) begin
        void'(mq.pop_front());
        consumed--;
      end
      if (r) consumed = 0;
      else if (y) consumed++;
      if (enq) mq.push_back(d);
    end
    idle_inputs();
    check_state(tag);
  endtask

  task automatic enq(input string tag, input logic [W-1:0] d);
    step(tag, 1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic yumi(input string tag);
    step(tag, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic commit(input string tag);
    step(tag, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic clear();
    step("clr", 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".ready"}, 32'(ready_and_o), 32'd1);
    check({tag, ".v_o"}, 32'(v_o), 32'd0);
    check({tag, ".empty"}, 32'(empty_o), 32'd1);
    check({tag, ".count"}, 32'(count_o), 32'd0);
  endtask

  initial begin
    logic v, y, c, r, cl;
    reset_i = 1'b1;
    idle_inputs();
    #2;
    check_reset_values("reset");
    @(posedge clk);
    #1;
    reset_i = 1'b0;

    // Fill to capacity, then drain in order.
    enq("fill0", 8'h11);
    enq("fill1", 8'h22);
    enq("fill2", 8'h33);
    enq("fill3", 8'h44);
    check("full.ready", 32'(ready_and_o), 32'd0);
    check("full.count", 32'(count_o), 32'd4);
    check("full.head", 32'(data_o), 32'h11);
    for (int i = 0; i < 4; i++) yumi("drain");
    check("drained.v_o", 32'(v_o), 32'd0);
    clear();

    // Replay after partial consumption.
    enq("a", 8'hA0); enq("b", 8'hB0); enq("c", 8'hC0); enq("d", 8'hD0);
    for (int i = 0; i < 3; i++) yumi("y3");
    step("roll", 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("roll.data", 32'(data_o), 32'hA0);
    check("roll.count", 32'(count_o), 32'd4);
    yumi("y2a"); yumi("y2b");
    commit("c2a"); commit("c2b");
    check("c2.count", 32'(count_o), 32'd2);
    check("c2.ready", 32'(ready_and_o), 32'd1);
    clear();

    // Full queue: commit frees a slot only for the following cycle.
    enq("f0", 8'h01); enq("f1", 8'h02); enq("f2", 8'h03); enq("f3", 8'h04);
    yumi("fy");
    step("yc_enq", 1'b1, 8'h05, 1'b1, 1'b1, 1'b0, 1'b0);
    check("nobypass.count", 32'(count_o), 32'd3);
    enq("late_enq", 8'h05);
    check("late.count", 32'(count_o), 32'd4);
    clear();

    // Roll together with commit lands one past the old commit point.
    enq("r0", 8'h5A); enq("r1", 8'h6B); enq("r2", 8'h7C); enq("r3", 8'h8D);
    for (int i = 0; i < 3; i++) yumi("ry");
    step("roll_commit", 1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("rc.data", 32'(data_o), 32'h6B);
    check("rc.count", 32'(count_o), 32'd3);

    // Clear beats concurrent enqueue, yumi and commit.
    step("clr_all", 1'b1, 8'hEE, 1'b1, 1'b1, 1'b0, 1'b1);
    check("clr.empty", 32'(empty_o), 32'd1);
    check("clr.v_o", 32'(v_o), 32'd0);
    check("clr.count", 32'(count_o), 32'd0);

    // Wrap cycles: enqueue 2, consume 2 (with random replay), commit 2.
    for (int k = 0; k < 20; k++) begin
      enq("w_e0", W'($urandom));
      enq("w_e1", W'($urandom));
      yumi("w_y0"); yumi("w_y1");
      if ($urandom_range(0, 1) == 1) begin
        step("w_roll", 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        yumi("w_ry0"); yumi("w_ry1");
      end
      commit("w_c0"); commit("w_c1");
    end

    // Random legal traffic with an asynchronous reset in the middle.
    for (int n = 0; n < 400; n++) begin
      if (n == 200) begin
        v_i = 1'b1; data_i = 8'h99;
        #2;
        reset_i = 1'b1;
        #1;
        check_reset_values("async_reset");
        mq.delete();
        consumed = 0;
        idle_inputs();
        @(posedge clk);
        #1;
        check_reset_values("held_reset");
        reset_i = 1'b0;
      end
      v  = 1'($urandom_range(0, 1));
      y  = (consumed < mq.size()) && ($urandom_range(0, 1) == 1);
      c  = (consumed > 0) && ($urandom_range(0, 1) == 1);
      r  = ($urandom_range(0, 7) == 0);
      cl = ($urandom_range(0, 49) == 0);
      step("rand", v, W'($urandom), y, c, r, cl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
